// File: rtl/attn_sram_pkg.sv
// Shared types and constants for the attention-score SRAM row streamer.
// No datapath logic lives here.
package attn_sram_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } rs_state_e;

  localparam int SRAM_RD_LAT = 2;

  // Width that holds outstanding reads plus buffered words without overflow.
  function automatic int credit_w(input int depth);
    return $clog2(depth) + 2;
  endfunction

endpackage

// File: rtl/attn_sync_fifo.sv
// Return-word buffer, DATA_W x DEPTH, flop storage; head is read from registered state.
// Zero-cycle pop visibility; a push while full is dropped (callers must never do it).
module attn_sync_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_dat_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] head_dat_o,
  output logic [CW-1:0]     count_o,
  output logic              empty_o,
  output logic              full_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q;
  logic              do_push, do_pop;

  assign empty_o    = (count_q == '0);
  assign full_o     = (count_q == CW'(DEPTH));
  assign do_push    = push_i && !full_o;
  assign do_pop     = pop_i && !empty_o;
  assign count_o    = count_q;
  assign head_dat_o = mem_q[rd_ptr_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_dat_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/attn_sram_row_streamer.sv
// Strided SRAM burst reader feeding a valid/ready stream; first word 4 cycles after cmd accept.
// Reads are credit-limited so outstanding + buffered never exceeds FIFO_DEPTH; out_ready=0 stalls issue.
module attn_sram_row_streamer
  import attn_sram_pkg::*;
#(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int LEN_W      = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_base,
  input  logic [ADDR_W-1:0] cmd_stride,
  input  logic [LEN_W-1:0]  cmd_len,
  output logic              sram_en,
  output logic              sram_re,
  output logic [ADDR_W-1:0] sram_addr,
  input  logic [DATA_W-1:0] sram_rdata,
  input  logic              sram_rvalid,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int SW = credit_w(FIFO_DEPTH);

  rs_state_e         state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d, stride_q, stride_d;
  logic [LEN_W-1:0]  issue_left_q, issue_left_d, beats_left_q, beats_left_d;
  logic [1:0]        outstanding_q, outstanding_d;
  logic              done_q, done_d;

  logic [CW-1:0] fifo_count;
  logic          fifo_empty, fifo_full;
  logic [SW-1:0] inflight;
  logic          issue, rv_accept, out_hs, cmd_hs;

  assign inflight  = SW'(outstanding_q) + SW'(fifo_count);
  assign issue     = (state_q == ISSUE) && (issue_left_q != '0) && (inflight < SW'(FIFO_DEPTH));
  // Returns with nothing outstanding belong to a burst killed by reset.
  assign rv_accept = sram_rvalid && (outstanding_q != 2'd0);
  assign out_valid = !fifo_empty;
  assign out_hs    = out_valid && out_ready;
  assign cmd_ready = rst_n && (state_q == IDLE);
  assign cmd_hs    = cmd_valid && cmd_ready;
  assign sram_en   = issue;
  assign sram_re   = issue;
  assign sram_addr = issue ? addr_q : '0;
  assign out_last  = out_valid && (beats_left_q == LEN_W'(1));
  assign busy      = (state_q != IDLE);
  assign done      = done_q;

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    stride_d      = stride_q;
    issue_left_d  = issue_left_q;
    beats_left_d  = beats_left_q;
    done_d        = 1'b0;
    outstanding_d = outstanding_q + 2'(issue) - 2'(rv_accept);
    if (out_hs) beats_left_d = beats_left_q - LEN_W'(1);
    case (state_q)
      IDLE: begin
        if (cmd_hs) begin
          addr_d       = cmd_base;
          stride_d     = cmd_stride;
          issue_left_d = cmd_len;
          beats_left_d = cmd_len;
          if (cmd_len != '0) state_d = ISSUE;
          else               done_d  = 1'b1;
        end
      end
      ISSUE: begin
        if (issue) begin
          addr_d       = addr_q + stride_q;
          issue_left_d = issue_left_q - LEN_W'(1);
          if (issue_left_q == LEN_W'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        // Leave on the final handshake itself so done lands in the very next cycle.
        if ((beats_left_q == '0) || (out_hs && beats_left_q == LEN_W'(1))) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      stride_q      <= '0;
      issue_left_q  <= '0;
      beats_left_q  <= '0;
      outstanding_q <= '0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      stride_q      <= stride_d;
      issue_left_q  <= issue_left_d;
      beats_left_q  <= beats_left_d;
      outstanding_q <= outstanding_d;
      done_q        <= done_d;
    end
  end

  attn_sync_fifo #(
    .DATA_W(DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push_i    (rv_accept),
    .push_dat_i(sram_rdata),
    .pop_i     (out_hs),
    .head_dat_o(out_data),
    .count_o   (fifo_count),
    .empty_o   (fifo_empty),
    .full_o    (fifo_full)
  );

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(rv_accept && fifo_full));
  a_rd_lat: assert property (@(posedge clk) disable iff (!rst_n) outstanding_q <= 2'(SRAM_RD_LAT));

endmodule

// File: doc/attn_sram_row_streamer.md
# attn_sram_row_streamer

Read-side controller for the attention-score word SRAM (read-only port A: 2-cycle latency, `a_en/a_re/a_addr` in, `a_rdata/a_rvalid` out). It accepts a strided burst command (base, stride, length), issues one SRAM read per cycle under a credit limit, and buffers returned words in a small FIFO. It presents them as a valid/ready stream with a `last` marker, so downstream score logic can apply backpressure without losing in-flight SRAM data.

## Interface
- `ADDR_W`, default 10: SRAM word-address width.
- `DATA_W`, default 32: SRAM word width.
- `LEN_W`, default 8: burst-length width. The maximum burst is 2^LEN_W−1 words.
- `FIFO_DEPTH`, default 4: return-buffer depth. Legal values are ≥4 and a power of two.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: block can accept a command. High only in IDLE.
- `cmd_base` in ADDR_W: first word address.
- `cmd_stride` in ADDR_W: address increment per word.
- `cmd_len` in LEN_W: number of words. A value of 0 is legal.
- `sram_en` out 1: drives SRAM `a_en`.
- `sram_re` out 1: drives SRAM `a_re`. Equal to `sram_en`.
- `sram_addr` out ADDR_W: drives SRAM `a_addr`.
- `sram_rdata` in DATA_W: from SRAM `a_rdata`.
- `sram_rvalid` in 1: from SRAM `a_rvalid`.
- `out_valid` out 1: stream data valid.
- `out_ready` in 1: downstream accepts data.
- `out_data` out DATA_W: stream word.
- `out_last` out 1: marks the final word of the burst.
- `busy` out 1: high from command accept until `done`.
- `done` out 1: one-cycle pulse at burst completion.

## Operation
- FSM states are IDLE, ISSUE and DRAIN.
  - IDLE: `cmd_ready`=1. On `cmd_valid`, latch base, stride and len into `addr_q` and `issue_left`. Also set `beats_left`=len.
  - If len≠0 the FSM goes to ISSUE. If len=0 it goes straight back to IDLE, and `done` pulses in the next cycle.
  - ISSUE: a read is issued when `issue_left`≠0 and `outstanding + fifo_count < FIFO_DEPTH`.
  - On each issue, `sram_en`=`sram_re`=1 and `sram_addr`=`addr_q`. Then `addr_q += stride` modulo 2^ADDR_W (wrap is silent) and `issue_left` decrements.
  - When the last read is issued, the FSM goes to DRAIN.
  - DRAIN: the FSM waits until `beats_left`=0, then goes to IDLE.
- `outstanding` is a 2-bit counter. It increments on issue, decrements on `sram_rvalid`, and both in the same cycle leave it unchanged.
- `sram_rvalid` with `outstanding`=0 is dropped, not written to the FIFO. This discards returns that arrive after a reset.
- Every accepted `sram_rvalid` pushes `sram_rdata` into the FIFO unconditionally. The credit rule guarantees the FIFO is never full at push time.
- An overflow is an assertion failure in simulation.
- `out_valid` = FIFO non-empty and `out_data` = FIFO head.
- A handshake (`out_valid & out_ready`) pops the FIFO and decrements `beats_left`.
- `out_last` = `out_valid & (beats_left==1)`.
- `done` pulses for 1 cycle in the cycle after the last-beat handshake. `busy` drops in that same cycle and `cmd_ready` is 1 again.
- A new command is never accepted while `busy`=1, so bursts do not overlap.
- Asynchronous reset, mid-burst included, returns the block to IDLE. It clears all counters and the FIFO.
- Output reset values: `cmd_ready`=0 while `rst_n`=0, then 1. All other outputs are 0.

## Timing
- Command accepted at the edge ending cycle t. First `sram_re` is in cycle t+1.
- Matching `sram_rvalid` is in cycle t+3. First `out_valid` is in cycle t+4, because the FIFO output is registered.
- With `out_ready` held at 1, one word per cycle is sustained. An N-word burst shows `out_last` in cycle t+3+N and `done` in cycle t+4+N.
- `out_ready`=0 stalls issue within at most FIFO_DEPTH−2 further reads. No data is lost.
- `out_data` and `out_last` are held stable while `out_valid & !out_ready`.
- The cmd handshake and the final-beat handshake cannot coincide, because `cmd_ready`=0 while busy.

## Structure
- Package `attn_sram_pkg` holds:
  - the `rs_state_e` enum (IDLE, ISSUE, DRAIN);
  - `localparam SRAM_RD_LAT = 2`;
  - the credit-width helper.
- Sub-module `attn_sync_fifo` is a parameterised DATA_W × FIFO_DEPTH FIFO with push, pop, count, empty and full, and a registered head. It uses the same clock and async active-low reset.

## Test plan
- Reset, then cmd base=0x010, stride=1, len=4, `out_ready`=1 → SRAM reads 0x010–0x013 in cycles t+1..t+4. Data appears in order from t+4, `out_last` in t+7, `done` in t+8.
- Stride=3, base=0x3FE, len=3 → addresses are 0x3FE, 0x001, 0x004 (wrap).
- len=16, `out_ready` toggled 1,0,0,1 repeating → all 16 words are delivered in order, the FIFO never overflows, and `outstanding + count ≤ 4` holds every cycle.
- cmd len=0 → accepted, no `sram_en`, `done` in t+1, `cmd_ready` high again in t+1.
- `rst_n` low for 1 cycle while 2 reads are outstanding → outputs go to 0 immediately. Late `sram_rvalid` is dropped, and the next burst's data is uncorrupted.
- `cmd_valid` held during a busy len=8 burst → second command accepted only in the `done` cycle, and its first read is in the cycle after.
